// File: rtl/alu_seq_pkg.sv
// Shared types and helpers for the ALU operation sequencer.
// Button vectors are ordered {U,L,C,R,D}: U is bit 4, D is bit 0.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEBOUNCE,
    ISSUE,
    SETTLE,
    CAPTURE,
    WAIT_RELEASE
  } seq_state_t;

  typedef enum logic [2:0] {
    OP_U,
    OP_L,
    OP_C,
    OP_R,
    OP_D
  } op_t;

  localparam int NUM_BTN = 5;

  // One-hot select for an operation, in {U,L,C,R,D} bit order.
  function automatic logic [NUM_BTN-1:0] onehot(input op_t op);
    logic [NUM_BTN-1:0] sel;
    case (op)
      OP_U:    sel = 5'b10000;
      OP_L:    sel = 5'b01000;
      OP_C:    sel = 5'b00100;
      OP_R:    sel = 5'b00010;
      OP_D:    sel = 5'b00001;
      default: sel = 5'b00000;
    endcase
    return sel;
  endfunction

  // Priority U > L > C > R > D. Callers only use the result when some bit is set.
  function automatic op_t prio_enc(input logic [NUM_BTN-1:0] b);
    op_t op;
    if (b[4])      op = OP_U;
    else if (b[3]) op = OP_L;
    else if (b[2]) op = OP_C;
    else if (b[1]) op = OP_R;
    else           op = OP_D;
    return op;
  endfunction

endpackage

// File: rtl/btn_sync2.sv
// Two-flop synchroniser for asynchronous button inputs.
module btn_sync2 #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;

  // Next values: shift raw input through two stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser registers, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Front-end controller for the 8-bit five-operation button ALU.
// Synchronises and debounces buttons, picks one op, registers operands,
// waits for the ALU to settle and captures the result into led.
// Optional feature macro: ALU_CHAIN_EN (chain=1 feeds led back as operand A).
// result_valid is a one-cycle pulse with no ready: the consumer must take led
// on that cycle or read the held led value later; there is no backpressure.
// DEBOUNCE_CYC must be at least 2.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int SETTLE_CYC   = 2,
  parameter int W            = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [4:0]   btn_raw,
  input  logic [W-1:0] sw_a,
  input  logic [W-1:0] sw_b,
  input  logic         chain,
  input  logic [W-1:0] alu_result,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [4:0]   alu_sel,
  output logic [W-1:0] led,
  output logic         result_valid,
  output logic         busy,
  output logic [7:0]   op_count
);

  // One counter serves debounce, settle and release timing.
  localparam int CNT_MAX = (DEBOUNCE_CYC > SETTLE_CYC) ? DEBOUNCE_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC);

  logic [4:0] btn_s;

  btn_sync2 #(.W(5)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_raw),
    .q     (btn_s)
  );

`ifndef ALU_CHAIN_EN
  // chain stays on the port list for pin compatibility only.
  logic unused_chain;
  assign unused_chain = chain;
`endif

  seq_state_t       state_q, state_d;
  op_t              op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [W-1:0]     alu_a_q, alu_a_d;
  logic [W-1:0]     alu_b_q, alu_b_d;
  logic [4:0]       alu_sel_q, alu_sel_d;
  logic [W-1:0]     led_q, led_d;
  logic             rv_q, rv_d;
  logic [7:0]       op_count_q, op_count_d;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state and datapath updates for the sequencer FSM.
  // The IDLE cycle that first sees a button counts as the first debounce
  // cycle, so DEBOUNCE leaves when the incremented count reaches the last value.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_sel_d  = alu_sel_q;
    led_d      = led_q;
    rv_d       = 1'b0;
    op_count_d = op_count_q;
    case (state_q)
      IDLE: begin
        if (|btn_s) begin
          state_d = DEBOUNCE;
          op_d    = prio_enc(btn_s);
          cnt_d   = '0;
        end
      end
      DEBOUNCE: begin
        if ((btn_s & onehot(op_q)) == 5'b00000) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == DEB_LAST) begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
`ifdef ALU_CHAIN_EN
        alu_a_d = chain ? led_q : sw_a;
`else
        alu_a_d = sw_a;
`endif
        alu_b_d   = sw_b;
        alu_sel_d = onehot(op_q);
        cnt_d     = '0;
        state_d   = SETTLE;
      end
      SETTLE: begin
        cnt_d = cnt_inc;
        if (cnt_inc == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        led_d      = alu_result;
        rv_d       = 1'b1;
        op_count_d = op_count_q + 8'd1;
        alu_sel_d  = 5'b00000;
        cnt_d      = '0;
        state_d    = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (|btn_s) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= OP_U;
      cnt_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_sel_q  <= '0;
      led_q      <= '0;
      rv_q       <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_sel_q  <= alu_sel_d;
      led_q      <= led_d;
      rv_q       <= rv_d;
      op_count_q <= op_count_d;
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_sel      = alu_sel_q;
  assign led          = led_q;
  assign result_valid = rv_q;
  assign busy         = (state_q != IDLE);
  assign op_count     = op_count_q;

endmodule
